// File: rtl/g9_run_ctrl_if.sv
// rtl/g9_run_ctrl_if.sv - control/status bundle between the board harness and the G9 run controller
interface g9_run_ctrl_if #(
   parameter int CNT_W = 32
) ();
   logic             start;
   logic             stop_req;
   logic             halt_detect;
   logic             step_req;
   logic             core_rst_n;
   logic             core_clk_en;
   logic [CNT_W-1:0] cycle_count;
   logic             running;
   logic             done;
   logic             timeout;

   modport master (
      output start, stop_req, halt_detect, step_req,
      input  core_rst_n, core_clk_en, cycle_count, running, done, timeout
   );

   modport slave (
      input  start, stop_req, halt_detect, step_req,
      output core_rst_n, core_clk_en, cycle_count, running, done, timeout
   );
endinterface

// File: rtl/g9_run_ctrl.sv
// rtl/g9_run_ctrl.sv - G9 core run controller: core reset, divided clock enable, cycle count, halt/timeout/step
module g9_run_ctrl #(
   parameter int DIV         = 2,
   parameter int RST_CYCLES  = 4,
   parameter int CNT_W       = 32,
   parameter int TIMEOUT_CYC = 1000
) (
   input logic           clk,
   input logic           rst_n,
   g9_run_ctrl_if.slave  bus
);
   localparam int DW = $clog2(DIV + 1);
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [63:0]      TO_VAL  = 64'(TIMEOUT_CYC);

   typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_HALTED, S_TIMEOUT} state_t;

   state_t           state, state_nx;
   logic [DW-1:0]    div_cnt, div_nx;
   logic [RW-1:0]    rst_cnt, rst_nx;
   logic [CNT_W-1:0] cnt_q, cnt_nx, cnt_inc;
   logic             en_q, en_nx;
   logic             armed, armed_nx;
   logic             enter_rst;
   logic             rstn_q, run_q, done_q, to_q;

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_nx  = state;
      div_nx    = div_cnt;
      rst_nx    = rst_cnt;
      cnt_nx    = cnt_q;
      en_nx     = 1'b0;
      enter_rst = 1'b0;
      // a step consumes the arm; only a low step_req re-arms it
      armed_nx  = armed | ~bus.step_req;
      case (state)
         S_IDLE: enter_rst = bus.start;
         S_RESET: begin
            if (rst_cnt == RW'(RST_CYCLES)) begin
               state_nx = S_RUN;
               div_nx   = DW'(1);
               en_nx    = (DIV == 1);
               if (DIV == 1) cnt_nx = cnt_inc;
            end else begin
               rst_nx = rst_cnt + 1'b1;
            end
         end
         S_RUN: begin
            if (bus.halt_detect || bus.stop_req) begin
               state_nx = S_HALTED;
            end else if (TIMEOUT_CYC != 0 && en_q && 64'(cnt_q) == TO_VAL) begin
               state_nx = S_TIMEOUT;
            end else begin
               div_nx = (div_cnt == DW'(DIV)) ? DW'(1) : div_cnt + 1'b1;
               en_nx  = (div_nx == DW'(DIV));
               if (en_nx) cnt_nx = cnt_inc;
            end
         end
         S_HALTED: begin
            if (bus.start) begin
               enter_rst = 1'b1;
            end else if (bus.step_req && armed) begin
               en_nx    = 1'b1;
               cnt_nx   = cnt_inc;
               armed_nx = 1'b0;
            end
         end
         S_TIMEOUT: enter_rst = bus.start;
         default: state_nx = S_IDLE;
      endcase
      if (enter_rst) begin
         state_nx = S_RESET;
         rst_nx   = RW'(1);
         cnt_nx   = '0;
         en_nx    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         div_cnt <= '0;
         rst_cnt <= '0;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         armed   <= 1'b1;
         rstn_q  <= 1'b0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state   <= state_nx;
         div_cnt <= div_nx;
         rst_cnt <= rst_nx;
         cnt_q   <= cnt_nx;
         en_q    <= en_nx;
         armed   <= armed_nx;
         rstn_q  <= (state_nx == S_RUN) || (state_nx == S_HALTED) || (state_nx == S_TIMEOUT);
         run_q   <= (state_nx == S_RUN);
         done_q  <= (state_nx == S_HALTED) || (state_nx == S_TIMEOUT);
         to_q    <= (state_nx == S_TIMEOUT);
      end
   end

   assign bus.core_rst_n  = rstn_q;
   assign bus.core_clk_en = en_q;
   assign bus.cycle_count = cnt_q;
   assign bus.running     = run_q;
   assign bus.done        = done_q;
   assign bus.timeout     = to_q;
endmodule

// File: tb/tb_g9_run_ctrl.sv
// tb/tb_g9_run_ctrl.sv - self-checking bench for g9_run_ctrl
module tb_g9_run_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   g9_run_ctrl_if #(.CNT_W(32)) a ();
   g9_run_ctrl_if #(.CNT_W(3))  b ();

   g9_run_ctrl #(.DIV(2), .RST_CYCLES(4), .CNT_W(32), .TIMEOUT_CYC(10)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(a.slave));
   g9_run_ctrl #(.DIV(1), .RST_CYCLES(4), .CNT_W(3), .TIMEOUT_CYC(0)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(b.slave));

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // reference model for u0: elapsed time since run entry, mod DIV gives enables
   localparam int MI = 0, MR = 1, MRUN = 2, MH = 3, MT = 4;
   localparam int DIVM = 2, RSTC = 4, TOM = 10;
   localparam longint MAXC = 64'hFFFF_FFFF;
   int     m_mode, m_rel, m_t;
   longint m_cnt;
   bit     m_en, m_armed;

   always @(posedge clk or negedge rst_n) begin
      int mode, rel, t;
      longint cnt;
      bit en, armed, go;
      if (!rst_n) begin
         m_mode <= MI; m_rel <= 0; m_t <= 0; m_cnt <= 0; m_en <= 0; m_armed <= 1;
      end else begin
         mode = m_mode; rel = m_rel; t = m_t; cnt = m_cnt;
         en = 0; go = 0; armed = m_armed || !a.step_req;
         case (m_mode)
            MI: go = a.start;
            MR: if (m_rel == RSTC) begin mode = MRUN; t = 1; en = (t % DIVM == 0); end
                else rel = m_rel + 1;
            MRUN: if (a.halt_detect || a.stop_req) mode = MH;
                  else if (TOM != 0 && m_en && m_cnt == TOM) mode = MT;
                  else begin t = m_t + 1; en = (t % DIVM == 0); end
            MH: if (a.start) go = 1;
                else if (a.step_req && m_armed) begin en = 1; armed = 0; end
            MT: go = a.start;
            default: mode = MI;
         endcase
         if (go) begin mode = MR; rel = 1; cnt = 0; en = 0; end
         if (en) cnt = (cnt == MAXC) ? cnt : cnt + 1;
         m_mode <= mode; m_rel <= rel; m_t <= t; m_cnt <= cnt; m_en <= en; m_armed <= armed;
      end
   end

   typedef struct {
      logic start, halt;
      logic e_rstn, e_run, e_en, e_done;
      int   e_cnt;
   } vec_t;
   vec_t tbl[12];

   int n;

   initial begin
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
      for (int i = 1; i <= 4; i++) tbl[i] = '{0, 0, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 0, 1, 1, 0, 0, 0};
      tbl[6]  = '{0, 0, 1, 1, 1, 0, 1};
      tbl[7]  = '{0, 0, 1, 1, 0, 0, 1};
      tbl[8]  = '{0, 0, 1, 1, 1, 0, 2};
      tbl[9]  = '{0, 0, 1, 1, 0, 0, 2};
      tbl[10] = '{0, 1, 1, 1, 1, 0, 3};
      tbl[11] = '{0, 0, 1, 0, 0, 1, 3};

      {a.start, a.stop_req, a.halt_detect, a.step_req} = '0;
      {b.start, b.stop_req, b.halt_detect, b.step_req} = '0;
      repeat (3) @(negedge clk);
      check("rst core_rst_n", a.core_rst_n, 0);
      check("rst en", a.core_clk_en, 0);
      check("rst cnt", a.cycle_count, 0);
      check("rst flags", {a.running, a.done, a.timeout}, 0);
      rst_n = 1'b1;

      // startup, then halt on the 3rd enable
      for (int i = 0; i < 12; i++) begin
         a.start = tbl[i].start;
         a.halt_detect = tbl[i].halt;
         check($sformatf("vec%0d rstn", i), a.core_rst_n, tbl[i].e_rstn);
         check($sformatf("vec%0d run", i), a.running, tbl[i].e_run);
         check($sformatf("vec%0d en", i), a.core_clk_en, tbl[i].e_en);
         check($sformatf("vec%0d done", i), a.done, tbl[i].e_done);
         check($sformatf("vec%0d cnt", i), a.cycle_count, tbl[i].e_cnt);
         @(negedge clk);
      end
      n = 0;
      repeat (20) begin n += a.core_clk_en; @(negedge clk); end
      check("halted no en", n, 0);
      check("halted cnt", a.cycle_count, 3);

      // single step with step_req held
      a.step_req = 1;
      n = 0;
      repeat (5) begin @(negedge clk); n += a.core_clk_en; end
      a.step_req = 0;
      repeat (3) begin @(negedge clk); n += a.core_clk_en; end
      check("step held en", n, 1);
      check("step held cnt", a.cycle_count, 4);
      a.step_req = 1;
      @(negedge clk);
      check("step2 en", a.core_clk_en, 1);
      a.step_req = 0;
      @(negedge clk);
      check("step2 cnt", a.cycle_count, 5);
      check("step2 en off", a.core_clk_en, 0);

      // start beats step
      a.start = 1; a.step_req = 1;
      @(negedge clk);
      a.start = 0; a.step_req = 0;
      check("restart rstn", a.core_rst_n, 0);
      check("restart cnt", a.cycle_count, 0);
      check("restart done", a.done, 0);
      check("restart en", a.core_clk_en, 0);

      // timeout at the 10th enable (cycle 24)
      repeat (23) @(negedge clk);
      check("to c24 en", a.core_clk_en, 1);
      check("to c24 cnt", a.cycle_count, 10);
      check("to c24 timeout", a.timeout, 0);
      @(negedge clk);
      check("to c25 timeout", a.timeout, 1);
      check("to c25 done", a.done, 1);
      check("to c25 run", a.running, 0);
      check("to c25 cnt", a.cycle_count, 10);
      a.step_req = 1;
      n = 0;
      repeat (4) begin @(negedge clk); n += a.core_clk_en; end
      a.step_req = 0;
      check("to step ignored", n, 0);
      check("to cnt hold", a.cycle_count, 10);

      // halt in the timeout cycle wins
      a.start = 1;
      @(negedge clk);
      a.start = 0;
      repeat (23) @(negedge clk);
      a.halt_detect = 1;
      check("toh c24 cnt", a.cycle_count, 10);
      @(negedge clk);
      a.halt_detect = 0;
      check("toh done", a.done, 1);
      check("toh timeout", a.timeout, 0);
      check("toh cnt", a.cycle_count, 10);

      // async reset mid-run
      a.start = 1;
      @(negedge clk);
      a.start = 0;
      repeat (7) @(negedge clk);
      check("mid en", a.core_clk_en, 1);
      check("mid cnt", a.cycle_count, 2);
      rst_n = 0;
      #1;
      check("mid rst rstn", a.core_rst_n, 0);
      check("mid rst en", a.core_clk_en, 0);
      check("mid rst cnt", a.cycle_count, 0);
      check("mid rst flags", {a.running, a.done, a.timeout}, 0);
      @(negedge clk);
      rst_n = 1;
      n = 0;
      repeat (10) begin @(negedge clk); n += a.core_clk_en; end
      check("post rst no en", n, 0);
      check("post rst rstn", a.core_rst_n, 0);

      // randomized against the model
      for (int i = 0; i < 3000; i++) begin
         check("rnd en", a.core_clk_en, m_en);
         check("rnd cnt", a.cycle_count, m_cnt);
         check("rnd flags", {a.core_rst_n, a.running, a.done, a.timeout},
               {m_mode >= MRUN, m_mode == MRUN, m_mode >= MH, m_mode == MT});
         a.start       = ($urandom_range(0, 29) == 0);
         a.stop_req    = ($urandom_range(0, 39) == 0);
         a.halt_detect = ($urandom_range(0, 39) == 0);
         a.step_req    = ($urandom_range(0, 2) == 0);
         @(negedge clk);
      end
      {a.start, a.stop_req, a.halt_detect, a.step_req} = '0;

      // DIV=1, 3-bit saturating counter, no timeout
      b.start = 1;
      @(negedge clk);
      b.start = 0;
      repeat (3) @(negedge clk);
      check("d1 reset en", b.core_clk_en, 0);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         check($sformatf("d1 k%0d en", k), b.core_clk_en, 1);
         check($sformatf("d1 k%0d cnt", k), b.cycle_count, (k > 7) ? 7 : k);
         check($sformatf("d1 k%0d to", k), b.timeout, 0);
      end
      b.stop_req = 1;
      @(negedge clk);
      b.stop_req = 0;
      @(negedge clk);
      check("d1 done", b.done, 1);
      check("d1 timeout", b.timeout, 0);
      check("d1 cnt", b.cycle_count, 7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/g9_run_ctrl.md
Name: g9_run_ctrl

Overview:
- Synthesizable run controller for the G9 processor core; replaces free-running clock toggling with a controlled start/reset/run/halt sequence.
- Sits between the board clock/reset and the core: generates the core reset, a divided clock-enable, a retired-cycle counter, halt/timeout detection and single-step.
- The core runs on clk gated by core_clk_en. No derived clocks.

Parameters:
- DIV, 2, clk cycles per core_clk_en pulse; must be ≥1, and 1 means enable every cycle.
- RST_CYCLES, 4, clk cycles core_rst_n is held low after start; must be ≥1.
- CNT_W, 32, width of cycle_count.
- TIMEOUT_CYC, 1000, core-cycle limit before forced stop; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level, sampled each clk; begins a reset+run sequence from IDLE, HALTED or TIMEOUT.
- stop_req  in  1  external halt request while running.
- halt_detect  in  1  core signals a halt instruction executed.
- step_req  in  1  in HALTED, issue exactly one core cycle.
- core_rst_n  out  1  active-low reset to the core.
- core_clk_en  out  1  one-clk-wide core advance pulse.
- cycle_count  out  CNT_W  number of core_clk_en pulses since last start; saturates at all-ones.
- running  out  1  high in RUN.
- done  out  1  high in HALTED or TIMEOUT.
- timeout  out  1  high in TIMEOUT only.

Behaviour:
- All outputs are registered. Async reset gives: state=IDLE, core_rst_n=0, core_clk_en=0, cycle_count=0, running=0, done=0, timeout=0, div and reset counters=0.
- States are IDLE, RESET, RUN, HALTED, TIMEOUT.
- IDLE:
  - core_rst_n=0. stop_req and step_req are ignored.
  - start → RESET. Entering RESET clears cycle_count, done and timeout.
- RESET:
  - core_rst_n=0 for exactly RST_CYCLES clk cycles, then → RUN.
  - start, stop_req, halt_detect and step_req are all ignored.
- RUN:
  - core_rst_n=1 and running=1 from the first RUN cycle.
  - The div counter restarts at RUN entry. core_clk_en is high in RUN cycles DIV, 2·DIV, …, counting the entry cycle as 1.
  - cycle_count increments in the same cycle core_clk_en is high.
  - start is ignored in RUN.
- Halt (RUN → HALTED):
  - Triggered by halt_detect or stop_req sampled high in a RUN cycle; HALTED starts the next cycle.
  - An enable pulse already scheduled for that sampling cycle still occurs. No core_clk_en is issued after it.
- Timeout (RUN → TIMEOUT):
  - Applies only when TIMEOUT_CYC≠0. When the pulse that brings cycle_count to TIMEOUT_CYC fires, the next cycle is TIMEOUT.
  - If halt_detect or stop_req is sampled in that same cycle, HALTED wins and timeout stays 0.
- HALTED:
  - done=1, running=0, core_rst_n stays 1 so core state remains inspectable.
  - step_req (sampled high) gives one core_clk_en pulse in the next cycle and cycle_count+1. It is not re-armed until step_req has been seen low.
  - Timeout is not evaluated during steps.
  - start → RESET; start has priority over step_req.
- TIMEOUT:
  - done=1, timeout=1, core_rst_n=1, no enables, step_req ignored.
  - start → RESET.
- cycle_count saturates at 2^CNT_W−1. Enables continue after saturation.
- Async rst_n mid-operation returns immediately to the reset values listed above, from any state.

Test Plan:
(All scenarios use DIV=2, RST_CYCLES=4, TIMEOUT_CYC=10 unless stated.)
1. Startup: release rst_n, start high at cycle 0 → core_rst_n low cycles 1–4, running=1 and core_rst_n=1 at cycle 5, core_clk_en at cycles 6, 8, 10; cycle_count=3 after cycle 10.
2. Halt: halt_detect pulsed in the cycle of the 3rd enable → that enable fires, cycle_count=3, HALTED next cycle (done=1, running=0), no further enables over 20 cycles.
3. Timeout: no halt → 10th enable at cycle 24, timeout=1 and done=1 from cycle 25, cycle_count=10. With halt_detect also high at cycle 24 → done=1, timeout=0.
4. Single-step: in HALTED with count=3, step_req held high 5 cycles → exactly one enable, count=4. Drop then re-raise step_req → count=5. start and step_req together → RESET, count=0.
5. Mid-run reset: assert rst_n low during RUN at count=2 → all outputs at reset values within the same cycle; no enables until a new start.
6. DIV=1, CNT_W=3, TIMEOUT_CYC=0 → enable every RUN cycle; count saturates at 7 and stays 7 while enables continue; timeout never asserts.
